// File: rtl/mdu_seq_if.sv
// EX-stage <-> multiply/divide unit connection: request, flush, stall and HI/LO commit.
interface mdu_seq_if;
  localparam int unsigned XLEN = 32;
  localparam int unsigned FW   = 6;

  logic            start;
  logic [FW-1:0]   funct;
  logic [XLEN-1:0] operand_1;
  logic [XLEN-1:0] operand_2;
  logic            flush;
  logic            stall_request;
  logic            busy;
  logic [XLEN-1:0] hi_write_data;
  logic [XLEN-1:0] lo_write_data;
  logic            hilo_write_en;

  // Pipeline side issues requests and consumes the HI/LO commit.
  modport master (
    output start, funct, operand_1, operand_2, flush,
    input  stall_request, busy, hi_write_data, lo_write_data, hilo_write_en
  );

  // Multiply/divide unit side.
  modport slave (
    input  start, funct, operand_1, operand_2, flush,
    output stall_request, busy, hi_write_data, lo_write_data, hilo_write_en
  );
endinterface

// File: rtl/mdu_seq.sv
// Sequential MIPS multiply/divide unit: 32-step shift-add multiply and
// restoring divide on operand magnitudes, sign fix-up at commit time.
module mdu_seq (
  input  logic     clk,
  input  logic     rst,
  mdu_seq_if.slave mdu
);
  localparam int unsigned XLEN = 32;
  localparam int unsigned CNTW = 6;

  localparam logic [5:0] FUNCT_MULT  = 6'h18;
  localparam logic [5:0] FUNCT_MULTU = 6'h19;
  localparam logic [5:0] FUNCT_DIV   = 6'h1A;
  localparam logic [5:0] FUNCT_DIVU  = 6'h1B;

  localparam logic [CNTW-1:0] LAST_STEP = CNTW'(31);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_e;

  state_e            state_q, state_d;
  logic [CNTW-1:0]   cnt_q, cnt_d;
  logic              is_mul_q, is_mul_d;
  logic              div_zero_q, div_zero_d;
  logic              neg_res_q, neg_res_d;
  logic              neg_rem_q, neg_rem_d;
  logic [XLEN-1:0]   op_a_q, op_a_d;
  logic [XLEN-1:0]   mcand_q, mcand_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   hi_q, hi_d;
  logic [XLEN-1:0]   lo_q, lo_d;

  logic              valid_funct, accept, is_mul_in, is_signed_in;
  logic              a_neg, b_neg;
  logic [XLEN-1:0]   mag_a, mag_b;
  logic [XLEN:0]     mul_sum, div_part, div_diff;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix, res_hi, res_lo;

  // Request decode and operand magnitudes.
  always_comb begin
    valid_funct  = mdu.funct inside {FUNCT_MULT, FUNCT_MULTU, FUNCT_DIV, FUNCT_DIVU};
    accept       = (state_q == S_IDLE) && mdu.start && valid_funct && !mdu.flush;
    is_mul_in    = (mdu.funct == FUNCT_MULT) || (mdu.funct == FUNCT_MULTU);
    is_signed_in = (mdu.funct == FUNCT_MULT) || (mdu.funct == FUNCT_DIV);
    a_neg        = is_signed_in && mdu.operand_1[XLEN-1];
    b_neg        = is_signed_in && mdu.operand_2[XLEN-1];
    mag_a        = a_neg ? -mdu.operand_1 : mdu.operand_1;
    mag_b        = b_neg ? -mdu.operand_2 : mdu.operand_2;
  end

  // Per-step datapath and sign-corrected final result.
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, mcand_q};
    div_part = acc_q[2*XLEN-1:XLEN-1];
    div_diff = div_part - {1'b0, mcand_q};
    prod_fix = neg_res_q ? -acc_q : acc_q;
    quo_fix  = neg_res_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    rem_fix  = neg_rem_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
    if (div_zero_q) begin
      res_hi = op_a_q;
      res_lo = '1;
    end else if (is_mul_q) begin
      res_hi = prod_fix[2*XLEN-1:XLEN];
      res_lo = prod_fix[XLEN-1:0];
    end else begin
      res_hi = rem_fix;
      res_lo = quo_fix;
    end
  end

  // Next-state logic: accept, iterate, commit; flush wins over everything.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    is_mul_d   = is_mul_q;
    div_zero_d = div_zero_q;
    neg_res_d  = neg_res_q;
    neg_rem_d  = neg_rem_q;
    op_a_d     = op_a_q;
    mcand_d    = mcand_q;
    acc_d      = acc_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d    = S_CALC;
          cnt_d      = '0;
          is_mul_d   = is_mul_in;
          div_zero_d = !is_mul_in && (mdu.operand_2 == '0);
          neg_res_d  = a_neg ^ b_neg;
          neg_rem_d  = a_neg;
          op_a_d     = mdu.operand_1;
          mcand_d    = is_mul_in ? mag_a : mag_b;
          acc_d      = {{XLEN{1'b0}}, (is_mul_in ? mag_b : mag_a)};
        end
      end
      S_CALC: begin
        if (mdu.flush) begin
          state_d = S_IDLE;
        end else if (div_zero_q) begin
          state_d = S_DONE;
        end else begin
          if (is_mul_q) begin
            acc_d = acc_q[0] ? {mul_sum, acc_q[XLEN-1:1]} : {1'b0, acc_q[2*XLEN-1:1]};
          end else begin
            acc_d = div_diff[XLEN] ? {div_part[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                                   : {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
          end
          if (cnt_q == LAST_STEP) state_d = S_DONE;
          else                    cnt_d   = cnt_q + CNTW'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        if (!mdu.flush) begin
          hi_d = res_hi;
          lo_d = res_lo;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      is_mul_q   <= 1'b0;
      div_zero_q <= 1'b0;
      neg_res_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      op_a_q     <= '0;
      mcand_q    <= '0;
      acc_q      <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      is_mul_q   <= is_mul_d;
      div_zero_q <= div_zero_d;
      neg_res_q  <= neg_res_d;
      neg_rem_q  <= neg_rem_d;
      op_a_q     <= op_a_d;
      mcand_q    <= mcand_d;
      acc_q      <= acc_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
    end
  end

  // Stall covers the accepting cycle so EX holds its operands until CALC owns them.
  assign mdu.stall_request = !rst && (accept || (state_q == S_CALC));
  assign mdu.busy          = (state_q != S_IDLE);
  assign mdu.hilo_write_en = (state_q == S_DONE) && !mdu.flush;
  assign mdu.hi_write_data = (state_q == S_DONE) ? res_hi : hi_q;
  assign mdu.lo_write_data = (state_q == S_DONE) ? res_lo : lo_q;
endmodule

// File: tb/tb_mdu_seq.sv
// Bench for mdu_seq: directed corner cases plus random operations checked
// against an arithmetic reference model.
module tb_mdu_seq;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;

  logic clk = 1'b0;
  logic rst;
  int   n_assert = 0;
  int   n_fail   = 0;
  logic [31:0] last_hi = '0;
  logic [31:0] last_lo = '0;

  always #5 clk = ~clk;

  mdu_seq_if bus ();

  mdu_seq dut (
    .clk (clk),
    .rst (rst),
    .mdu (bus.slave)
  );

  // One comparison.
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference result {hi, lo} from plain arithmetic.
  function automatic logic [63:0] model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    int q, r;
    case (f)
      F_MULT:  p = 64'(longint'($signed(a)) * longint'($signed(b)));
      F_MULTU: p = {32'd0, a} * {32'd0, b};
      default: begin
        if (b == 32'd0)                                  p = {a, 32'hFFFF_FFFF};
        else if (f == F_DIVU)                            p = {a % b, a / b};
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) p = {32'd0, 32'h8000_0000};
        else begin
          q = $signed(a) / $signed(b);
          r = $signed(a) % $signed(b);
          p = {r, q};
        end
      end
    endcase
    return p;
  endfunction

  // Issue one operation at the current negedge and check the whole transaction.
  task automatic run_op(input string tag, input logic [5:0] f, input logic [31:0] a,
                        input logic [31:0] b, input bit mid_start, input bit done_start);
    logic [63:0] exp;
    int exp_lat, lat;
    bit stall_ok, seen;
    exp     = model(f, a, b);
    exp_lat = ((f == F_DIV || f == F_DIVU) && b == 32'd0) ? 2 : 33;
    bus.funct = f; bus.operand_1 = a; bus.operand_2 = b; bus.flush = 1'b0; bus.start = 1'b1;
    #1;
    chk({tag, " stall_accept"}, 64'(bus.stall_request), 64'(1));
    stall_ok = 1'b1; seen = 1'b0; lat = 0;
    while (lat < 40 && !seen) begin
      @(negedge clk);
      lat++;
      bus.start = mid_start && (lat == 5);
      if (bus.start) bus.funct = F_MULTU;
      bus.operand_1 = $urandom;
      bus.operand_2 = $urandom;
      #1;
      if (bus.hilo_write_en === 1'b1) seen = 1'b1;
      else if (bus.stall_request !== 1'b1 || bus.busy !== 1'b1) stall_ok = 1'b0;
    end
    chk({tag, " latency"}, 64'(lat), 64'(exp_lat));
    chk({tag, " stall_calc"}, 64'(stall_ok), 64'(1));
    chk({tag, " hi"}, 64'(bus.hi_write_data), 64'(exp[63:32]));
    chk({tag, " lo"}, 64'(bus.lo_write_data), 64'(exp[31:0]));
    chk({tag, " stall_done"}, 64'(bus.stall_request), 64'(0));
    if (done_start) begin
      bus.start = 1'b1;
      bus.funct = F_MULTU;
    end
    @(negedge clk);
    chk({tag, " en_one_cycle"}, 64'(bus.hilo_write_en), 64'(0));
    chk({tag, " busy_after"}, 64'(bus.busy), 64'(0));
    chk({tag, " hi_hold"}, 64'(bus.hi_write_data), 64'(exp[63:32]));
    chk({tag, " lo_hold"}, 64'(bus.lo_write_data), 64'(exp[31:0]));
    bus.start = 1'b0;
    last_hi = exp[63:32];
    last_lo = exp[31:0];
  endtask

  initial begin
    logic [5:0]  fl [4];
    logic [31:0] ra, rb;
    bit          bad_en;
    fl[0] = F_MULT; fl[1] = F_MULTU; fl[2] = F_DIV; fl[3] = F_DIVU;

    // Reset state, with a request pending that must not stall.
    rst = 1'b1;
    bus.start = 1'b1; bus.funct = F_MULTU; bus.operand_1 = '0; bus.operand_2 = '0; bus.flush = 1'b0;
    #1;
    chk("reset stall", 64'(bus.stall_request), 64'(0));
    chk("reset busy", 64'(bus.busy), 64'(0));
    chk("reset en", 64'(bus.hilo_write_en), 64'(0));
    chk("reset hi", 64'(bus.hi_write_data), 64'(0));
    chk("reset lo", 64'(bus.lo_write_data), 64'(0));
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Directed arithmetic corners.
    run_op("multu_max", F_MULTU, 32'hFFFF_FFFF, 32'h0000_0002, 1'b0, 1'b0);
    run_op("mult_neg",  F_MULT,  32'hFFFF_FFFD, 32'h0000_0005, 1'b1, 1'b0);
    run_op("div_neg",   F_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 1'b0, 1'b1);
    run_op("div_ovf",   F_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
    run_op("divu_zero", F_DIVU,  32'd100,       32'd0,         1'b0, 1'b1);
    run_op("div_zero",  F_DIV,   32'hFFFF_FF00, 32'd0,         1'b0, 1'b0);

    // Invalid funct must be ignored.
    bus.start = 1'b1; bus.funct = 6'h20;
    #1;
    chk("bad_funct stall", 64'(bus.stall_request), 64'(0));
    @(negedge clk);
    chk("bad_funct busy", 64'(bus.busy), 64'(0));
    bus.start = 1'b0;

    // Flush mid-CALC: no commit, HI/LO unchanged, restart two cycles later.
    bus.funct = F_DIVU; bus.operand_1 = 32'd100; bus.operand_2 = 32'd7; bus.start = 1'b1;
    bad_en = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      bus.start = 1'b0;
      #1;
      if (bus.hilo_write_en !== 1'b0) bad_en = 1'b1;
    end
    bus.flush = 1'b1;
    #1;
    chk("flush en", 64'(bus.hilo_write_en | bad_en), 64'(0));
    @(negedge clk);
    bus.flush = 1'b0;
    chk("flush busy", 64'(bus.busy), 64'(0));
    chk("flush hi", 64'(bus.hi_write_data), 64'(last_hi));
    chk("flush lo", 64'(bus.lo_write_data), 64'(last_lo));
    @(negedge clk);
    run_op("after_flush", F_DIVU, 32'd100, 32'd7, 1'b0, 1'b0);

    // Reset mid-CALC: outputs clear at once, restart right after release.
    bus.funct = F_MULT; bus.operand_1 = 32'h1234_5678; bus.operand_2 = 32'h9ABC_DEF0; bus.start = 1'b1;
    repeat (5) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    rst = 1'b1;
    #1;
    chk("midrst busy", 64'(bus.busy), 64'(0));
    chk("midrst stall", 64'(bus.stall_request), 64'(0));
    chk("midrst en", 64'(bus.hilo_write_en), 64'(0));
    chk("midrst hi", 64'(bus.hi_write_data), 64'(0));
    chk("midrst lo", 64'(bus.lo_write_data), 64'(0));
    @(negedge clk);
    chk("midrst en_held", 64'(bus.hilo_write_en), 64'(0));
    rst = 1'b0;
    run_op("after_rst", F_DIVU, 32'd100, 32'd7, 1'b0, 1'b0);

    // Random operations against the reference model.
    for (int i = 0; i < 16; i++) begin
      ra = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = 32'd0;
        1:       rb = $urandom_range(1, 15);
        default: rb = $urandom;
      endcase
      if (i % 3 == 0) ra = 32'($urandom_range(0, 1000));
      run_op($sformatf("rand%0d", i), fl[$urandom_range(0, 3)], ra, rb, (i % 4) == 1, (i % 5) == 2);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/mdu_seq.md
MDU_SEQ -- requirements
Module: mdu_seq

Interface
REQ-001 SHALL have one clock and an asynchronous, active-high reset (clk, rst); all state SHALL update on posedge clk.
REQ-002 Ports (name  direction  width  meaning):
- clk  in  1  clock
- rst  in  1  async active-high reset
- start  in  1  EX requests a multiply/divide this cycle
- funct  in  6  `FUNCT_MULT/MULTU/DIV/DIVU; any other value ignored
- operand_1  in  32  multiplicand / dividend
- operand_2  in  32  multiplier / divisor
- flush  in  1  abort the in-flight operation
- stall_request  out  1  hold IF/ID/EX while an operation is in progress
- busy  out  1  FSM not IDLE
- hi_write_data  out  32  HI result (product high word / remainder)
- lo_write_data  out  32  LO result (product low word / quotient)
- hilo_write_en  out  1  one-cycle HI/LO commit strobe

Function
REQ-003 FSM states SHALL be IDLE, CALC, DONE.
REQ-004 IDLE: start=1 with a valid funct and flush=0 SHALL latch the operands and funct, clear the 6-bit iteration counter, and go to CALC; otherwise stay in IDLE.
REQ-005 stall_request SHALL be combinationally 1 in the accepting IDLE cycle and SHALL stay 1 throughout CALC; it SHALL be 0 in DONE and IDLE.
REQ-006 Signed ops (MULT, DIV) SHALL first convert the operands to magnitudes; unsigned ops SHALL use them as-is.
REQ-007 Multiply: one shift-add step per CALC cycle over 32 cycles, giving a 64-bit magnitude product.
REQ-008 Divide: one restoring shift-subtract step per CALC cycle over 32 cycles, giving a 32-bit quotient and a 32-bit remainder.
REQ-009 CALC SHALL go to DONE after the counter reaches 31, i.e. exactly 32 CALC cycles.
REQ-010 Divide by zero (operand_2==0, DIV or DIVU) SHALL skip iteration: IDLE->CALC->DONE with a single CALC cycle, result hi=operand_1, lo=32'hFFFFFFFF.
REQ-011 Sign fix-up for MULT: negate the 64-bit product if the operand signs differ.
REQ-012 Sign fix-up for DIV: negate the quotient if the operand signs differ; the remainder takes the dividend's sign.
REQ-013 DIV 0x80000000 / 0xFFFFFFFF SHALL yield lo=0x80000000, hi=0 with no exception.
REQ-014 DONE SHALL drive hilo_write_en=1 for exactly one cycle with the final hi/lo values, then return to IDLE.
REQ-015 Latency: for an operation accepted at cycle T, hilo_write_en SHALL be high at T+33 (T+2 for divide by zero).
REQ-016 hi_write_data/lo_write_data SHALL hold their last committed values outside DONE.
REQ-017 busy SHALL be 1 in CALC and DONE.
REQ-018 start in CALC or DONE SHALL be ignored.
REQ-019 start in the same cycle that DONE exits SHALL NOT be accepted; acceptance requires the IDLE state.
REQ-020 flush=1 in CALC or DONE SHALL return to IDLE next cycle with no hilo_write_en pulse; flush has priority over start and over completion.
REQ-021 start with an invalid funct SHALL leave the FSM in IDLE with stall_request=0.

Reset
REQ-022 rst=1 SHALL immediately force state IDLE, counter 0, stall_request 0, busy 0, hilo_write_en 0, hi_write_data 0, lo_write_data 0, and clear all internal operand/accumulator registers.
REQ-023 Reset mid-operation SHALL discard the operation with no HI/LO write, and the block SHALL accept a new start on the first clock after rst deasserts.

Verification
REQ-024 MULTU 0xFFFFFFFF*0x00000002 accepted at T -> hilo_write_en=1 only at T+33 with hi=0x00000001, lo=0xFFFFFFFE; stall_request high T..T+32.
REQ-025 MULT 0xFFFFFFFD(-3)*0x00000005 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1.
REQ-026 DIV 0xFFFFFFF9(-7)/0x00000002 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-027 DIVU 100/0 at T -> hilo_write_en at T+2 with hi=100, lo=0xFFFFFFFF.
REQ-028 DIVU 100/7 started, flush at T+10 -> IDLE at T+11, no hilo_write_en, hi/lo unchanged; new start at T+12 is accepted.
REQ-029 rst asserted mid-CALC -> outputs zero immediately, no commit; start one cycle after release completes normally (DIVU 100/7 -> lo=14, hi=2).
